// File: rtl/ysyx_22040750_pc_redirect_ctrl_pkg.sv
// Shared encodings for the next-PC redirect controller.
// States, redirect priority codes and the default boot PC.
package ysyx_22040750_pc_redirect_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] prio_t;

    localparam state_t ST_BOOT = 2'd0;
    localparam state_t ST_IDLE = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_INV  = 2'd3;

    localparam prio_t PRIO_TRAP   = 2'd3;
    localparam prio_t PRIO_FENCEI = 2'd2;
    localparam prio_t PRIO_EX     = 2'd1;
    localparam prio_t PRIO_ID     = 2'd0;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22040750_pc_redirect_ctrl_prio_sel.sv
// Fixed-priority pick among trap, fence.i, EX and ID redirects.
// Returns the winning valid flag, its priority code and its target.
module ysyx_22040750_redir_prio_sel
    import ysyx_22040750_pc_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_trap_v,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic            i_fencei_v,
    input  logic [XLEN-1:0] i_fencei_pc,
    input  logic            i_ex_v,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic            i_id_v,
    input  logic [XLEN-1:0] i_id_pc,
    output logic            o_valid,
    output prio_t           o_prio,
    output logic [XLEN-1:0] o_pc
);

    always_comb begin
        o_valid = 1'b1;
        o_prio  = PRIO_ID;
        o_pc    = i_id_pc;
        if (i_trap_v) begin
            o_prio = PRIO_TRAP;
            o_pc   = i_trap_pc;
        end else if (i_fencei_v) begin
            o_prio = PRIO_FENCEI;
            o_pc   = i_fencei_pc;
        end else if (i_ex_v) begin
            o_prio = PRIO_EX;
            o_pc   = i_ex_pc;
        end else if (!i_id_v) begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22040750_pc_redirect_ctrl.sv
// Next-PC sequencer: redirect arbitration, pending-target hold,
// pipeline flushes and the fence.i I-cache invalidate handshake.
module ysyx_22040750_pc_redirect_ctrl
    import ysyx_22040750_pc_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            I_clk,
    input  logic            I_rst_n,
    input  logic            I_trap_valid,
    input  logic [XLEN-1:0] I_trap_pc,
    input  logic            I_fencei_valid,
    input  logic [XLEN-1:0] I_fencei_pc,
    input  logic            I_ex_redir_valid,
    input  logic [XLEN-1:0] I_ex_redir_pc,
    input  logic            I_id_redir_valid,
    input  logic [XLEN-1:0] I_id_redir_pc,
    input  logic [XLEN-1:0] I_snpc,
    input  logic            I_pc_ready,
    output logic            O_pc_valid,
    output logic [XLEN-1:0] O_dnpc,
    output logic            O_redirect,
    output logic            O_flush_ifid,
    output logic            O_flush_idex,
    output logic            O_icache_inv_req,
    input  logic            I_icache_inv_done,
    output logic            O_busy
);

    state_t          r_state;
    logic [XLEN-1:0] r_pend_pc;
    prio_t           r_pend_prio;

    state_t          w_nxt_state;
    logic [XLEN-1:0] w_nxt_pc;
    prio_t           w_nxt_prio;

    logic            w_sel_v;
    prio_t           w_sel_prio;
    logic [XLEN-1:0] w_sel_pc;
    logic            w_sel_fi;
    logic            w_acc;
    logic            w_valid;
    logic            w_redir;
    logic            w_inv;
    logic            w_busy;
    logic [XLEN-1:0] w_dnpc;

    // fence.i competes with the address of the instruction after it
    logic [XLEN-1:0] w_fi_tgt;
    assign w_fi_tgt = I_fencei_pc + XLEN'(4);

    ysyx_22040750_redir_prio_sel #(
        .XLEN (XLEN)
    ) u_sel (
        .i_trap_v    (I_trap_valid),
        .i_trap_pc   (I_trap_pc),
        .i_fencei_v  (I_fencei_valid),
        .i_fencei_pc (w_fi_tgt),
        .i_ex_v      (I_ex_redir_valid),
        .i_ex_pc     (I_ex_redir_pc),
        .i_id_v      (I_id_redir_valid),
        .i_id_pc     (I_id_redir_pc),
        .o_valid     (w_sel_v),
        .o_prio      (w_sel_prio),
        .o_pc        (w_sel_pc)
    );

    assign w_sel_fi = w_sel_v && (w_sel_prio == PRIO_FENCEI);

    always_comb begin
        w_acc = 1'b0;
        case (r_state)
            ST_IDLE: w_acc = w_sel_v;
            ST_HOLD: w_acc = w_sel_v && (w_sel_prio > r_pend_prio);
            ST_INV:  w_acc = w_sel_v && (w_sel_prio == PRIO_TRAP);
            default: w_acc = 1'b0;
        endcase
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pend_pc;
        w_nxt_prio  = r_pend_prio;
        if (w_acc) begin
            w_nxt_pc   = {w_sel_pc[XLEN-1:1], 1'b0};
            w_nxt_prio = w_sel_prio;
        end
        case (r_state)
            ST_BOOT: if (I_pc_ready) w_nxt_state = ST_IDLE;
            ST_IDLE: begin
                if (w_sel_fi)
                    w_nxt_state = ST_INV;
                else if (w_sel_v && !I_pc_ready)
                    w_nxt_state = ST_HOLD;
            end
            ST_HOLD: begin
                // a late fence.i still has to invalidate before refetching
                if (w_acc && w_sel_fi)
                    w_nxt_state = ST_INV;
                else if (!w_acc && I_pc_ready)
                    w_nxt_state = ST_IDLE;
            end
            ST_INV: if (I_icache_inv_done) w_nxt_state = ST_HOLD;
            default: w_nxt_state = ST_BOOT;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state     <= ST_BOOT;
            r_pend_pc   <= RESET_PC;
            r_pend_prio <= PRIO_ID;
        end else begin
            r_state     <= w_nxt_state;
            r_pend_pc   <= w_nxt_pc;
            r_pend_prio <= w_nxt_prio;
        end
    end

    always_comb begin
        w_valid = 1'b0;
        w_redir = 1'b0;
        w_inv   = 1'b0;
        w_busy  = 1'b0;
        w_dnpc  = r_pend_pc;
        case (r_state)
            ST_BOOT: begin
                w_valid = 1'b1;
                w_redir = 1'b1;
                w_busy  = 1'b1;
                w_dnpc  = RESET_PC;
            end
            ST_IDLE: begin
                w_valid = !w_sel_fi;
                w_redir = w_sel_v;
                w_dnpc  = w_sel_v ? w_sel_pc : I_snpc;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                w_redir = 1'b1;
            end
            default: begin
                w_inv  = 1'b1;
                w_busy = 1'b1;
            end
        endcase
    end

    assign O_pc_valid       = I_rst_n && w_valid;
    assign O_redirect       = I_rst_n && w_redir;
    assign O_icache_inv_req = I_rst_n && w_inv;
    assign O_busy           = !I_rst_n || w_busy;
    assign O_dnpc           = {w_dnpc[XLEN-1:1], 1'b0};
    assign O_flush_ifid     = I_rst_n && w_acc;
    assign O_flush_idex     = I_rst_n && w_acc && (w_sel_prio != PRIO_ID);

endmodule

// File: tb/tb_ysyx_22040750_pc_redirect_ctrl.sv
// Scenario bench for the next-PC redirect controller.
// Expected output vectors are queued at drive time and popped at negedge.
module tb_ysyx_22040750_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_v, fi_v, ex_v, id_v, ready, done;
    logic [31:0] trap_pc, fi_pc, ex_pc, id_pc, snpc;
    logic        pc_valid, redirect, fl_ifid, fl_idex, inv_req, busy;
    logic [31:0] dnpc;

    int total = 0;
    int bad   = 0;
    logic [37:0] sb[$];

    always #5 clk = ~clk;

    ysyx_22040750_pc_redirect_ctrl dut (
        .I_clk             (clk),
        .I_rst_n           (rst_n),
        .I_trap_valid      (trap_v),
        .I_trap_pc         (trap_pc),
        .I_fencei_valid    (fi_v),
        .I_fencei_pc       (fi_pc),
        .I_ex_redir_valid  (ex_v),
        .I_ex_redir_pc     (ex_pc),
        .I_id_redir_valid  (id_v),
        .I_id_redir_pc     (id_pc),
        .I_snpc            (snpc),
        .I_pc_ready        (ready),
        .O_pc_valid        (pc_valid),
        .O_dnpc            (dnpc),
        .O_redirect        (redirect),
        .O_flush_ifid      (fl_ifid),
        .O_flush_idex      (fl_idex),
        .O_icache_inv_req  (inv_req),
        .I_icache_inv_done (done),
        .O_busy            (busy)
    );

    localparam logic [31:0] RST = 32'h8000_0000;
    localparam logic [31:0] SEQ = 32'h8000_0004;

    function automatic logic [37:0] E(input logic v, input logic r,
                                      input logic fi, input logic fx,
                                      input logic inv, input logic bz,
                                      input logic [31:0] pc);
        return {v, r, fi, fx, inv, bz, pc};
    endfunction

    function automatic logic [37:0] obs();
        return {pc_valid, redirect, fl_ifid, fl_idex, inv_req, busy, dnpc};
    endfunction

    task automatic clr();
        trap_v = 0; fi_v = 0; ex_v = 0; id_v = 0; done = 0;
        ready = 1; snpc = SEQ;
        trap_pc = '0; fi_pc = '0; ex_pc = '0; id_pc = '0;
    endtask

    task automatic test_reset();
        logic [37:0] got, want;
        rst_n = 0;
        clr();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: sb.push_back(E(0, 0, 0, 0, 0, 1, RST));
                1: begin
                    rst_n = 1;
                    sb.push_back(E(1, 1, 0, 0, 0, 1, RST));
                end
                default: sb.push_back(E(1, 0, 0, 0, 0, 0, SEQ));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ex_hold();
        logic [37:0] got, want;
        for (int k = 0; k < 5; k++) begin
            clr();
            case (k)
                0: begin
                    ex_v = 1; ex_pc = 32'h8000_0100; ready = 0;
                    sb.push_back(E(1, 1, 1, 1, 0, 0, 32'h8000_0100));
                end
                1, 2: begin
                    ready = 0;
                    sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0100));
                end
                3: sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0100));
                default: begin
                    snpc = 32'h8000_0104;
                    sb.push_back(E(1, 0, 0, 0, 0, 0, 32'h8000_0104));
                end
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ex_hold[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ex_id_both();
        logic [37:0] got, want;
        for (int k = 0; k < 3; k++) begin
            clr();
            case (k)
                0: begin
                    ex_v = 1; ex_pc = 32'h8000_0180;
                    id_v = 1; id_pc = 32'h8000_0280;
                    sb.push_back(E(1, 1, 1, 1, 0, 0, 32'h8000_0180));
                end
                1: begin
                    id_v = 1; id_pc = 32'h8000_0301;
                    sb.push_back(E(1, 1, 1, 0, 0, 0, 32'h8000_0300));
                end
                default: sb.push_back(E(1, 0, 0, 0, 0, 0, SEQ));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ex_id[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold_trap();
        logic [37:0] got, want;
        for (int k = 0; k < 6; k++) begin
            clr();
            case (k)
                0: begin
                    id_v = 1; id_pc = 32'h8000_0200; ready = 0;
                    sb.push_back(E(1, 1, 1, 0, 0, 0, 32'h8000_0200));
                end
                1: begin
                    trap_v = 1; trap_pc = 32'h8000_0040;
                    sb.push_back(E(1, 1, 1, 1, 0, 0, 32'h8000_0200));
                end
                2: begin
                    id_v = 1; id_pc = 32'h8000_0300; ready = 0;
                    sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0040));
                end
                3: begin
                    ex_v = 1; ex_pc = 32'h8000_0500; ready = 0;
                    sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0040));
                end
                4: begin
                    trap_v = 1; trap_pc = 32'h8000_0998;
                    sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0040));
                end
                default: sb.push_back(E(1, 0, 0, 0, 0, 0, SEQ));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hold_trap[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fencei();
        logic [37:0] got, want;
        for (int k = 0; k < 8; k++) begin
            clr();
            case (k)
                0: begin
                    fi_v = 1; fi_pc = 32'hFFFF_FFFC;
                    sb.push_back(E(0, 1, 1, 1, 0, 0, 32'h0000_0000));
                end
                1, 3, 4: sb.push_back(E(0, 0, 0, 0, 1, 1, 32'h0));
                2: begin
                    ex_v = 1; ex_pc = 32'h8000_0600;
                    sb.push_back(E(0, 0, 0, 0, 1, 1, 32'h0));
                end
                5: begin
                    done = 1;
                    sb.push_back(E(0, 0, 0, 0, 1, 1, 32'h0));
                end
                6: sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h0));
                default: sb.push_back(E(1, 0, 0, 0, 0, 0, SEQ));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fencei[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap_inv();
        logic [37:0] got, want;
        for (int k = 0; k < 7; k++) begin
            clr();
            case (k)
                0: begin
                    fi_v = 1; fi_pc = 32'h8000_1000;
                    sb.push_back(E(0, 1, 1, 1, 0, 0, 32'h8000_1004));
                end
                1: sb.push_back(E(0, 0, 0, 0, 1, 1, 32'h8000_1004));
                2: begin
                    trap_v = 1; trap_pc = 32'h8000_0040;
                    sb.push_back(E(0, 0, 1, 1, 1, 1, 32'h8000_1004));
                end
                3: sb.push_back(E(0, 0, 0, 0, 1, 1, 32'h8000_0040));
                4: begin
                    done = 1;
                    sb.push_back(E(0, 0, 0, 0, 1, 1, 32'h8000_0040));
                end
                5: sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0040));
                default: sb.push_back(E(1, 0, 0, 0, 0, 0, SEQ));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL trap_inv[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [37:0] got, want;
        for (int k = 0; k < 6; k++) begin
            clr();
            case (k)
                0: begin
                    ex_v = 1; ex_pc = 32'h8000_0700; ready = 0;
                    sb.push_back(E(1, 1, 1, 1, 0, 0, 32'h8000_0700));
                end
                1: begin
                    ready = 0;
                    sb.push_back(E(1, 1, 0, 0, 0, 0, 32'h8000_0700));
                end
                2: begin
                    rst_n = 0;
                    sb.push_back(E(0, 0, 0, 0, 0, 1, RST));
                end
                3: begin
                    rst_n = 1; ready = 0;
                    sb.push_back(E(1, 1, 0, 0, 0, 1, RST));
                end
                4: sb.push_back(E(1, 1, 0, 0, 0, 1, RST));
                default: sb.push_back(E(1, 0, 0, 0, 0, 0, SEQ));
            endcase
            @(negedge clk);
            got = obs(); want = sb.pop_front(); total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rst_hold[%0d] got=%b/%h want=%b/%h",
                         k, got[37:32], got[31:0], want[37:32], want[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_ex_hold();
        test_ex_id_both();
        test_hold_trap();
        test_fencei();
        test_trap_inv();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_pc_redirect_ctrl.md
Name: ysyx_22040750_pc_redirect_ctrl

Overview:
- Sequences the next-PC datapath for the in-order pipeline.
- Arbitrates redirect requests from trap/CSR, fence.i, EX-stage branch/jalr and ID-stage jal against the sequential snpc.
- Holds the winning target until the PC register accepts it, and generates the IF/ID and ID/EX flushes.
- Runs the fence.i I-cache invalidate handshake before redirecting to the instruction after fence.i.

Parameters:
- XLEN, 32, address width of all PC ports
- RESET_PC, 32'h8000_0000, first PC issued after reset

Ports:
- I_clk  in  1  clock, all state on rising edge
- I_rst_n  in  1  asynchronous, active-low reset
- I_trap_valid  in  1  trap/interrupt/mret redirect request
- I_trap_pc  in  XLEN  trap target (mtvec/mepc)
- I_fencei_valid  in  1  fence.i reached EX
- I_fencei_pc  in  XLEN  PC of the fence.i instruction
- I_ex_redir_valid  in  1  taken branch or jalr resolved in EX
- I_ex_redir_pc  in  XLEN  EX target, bit0 already cleared
- I_id_redir_valid  in  1  jal decoded in ID
- I_id_redir_pc  in  XLEN  jal target
- I_snpc  in  XLEN  sequential next PC
- I_pc_ready  in  1  PC register accepts O_dnpc
- O_pc_valid  out  1  O_dnpc valid
- O_dnpc  out  XLEN  next PC
- O_redirect  out  1  O_dnpc is non-sequential
- O_flush_ifid  out  1  kill the IF/ID entry
- O_flush_idex  out  1  kill the ID/EX entry
- O_icache_inv_req  out  1  I-cache invalidate request
- I_icache_inv_done  in  1  one-cycle invalidate-complete pulse
- O_busy  out  1  high in BOOT and INV; fetch must stall

Behaviour:
- Reset (I_rst_n=0, asynchronous): state=BOOT, pend_pc=RESET_PC, pend_prio=0. Outputs during reset: O_pc_valid=0, O_redirect=0, flushes=0, O_icache_inv_req=0, O_busy=1, O_dnpc=RESET_PC.
- States:
  - BOOT: O_pc_valid=1, O_dnpc=RESET_PC, O_redirect=1. On I_pc_ready -> IDLE. All requests ignored.
  - IDLE: O_pc_valid=1. O_dnpc is the combinational winner, priority trap > fencei > ex > id > snpc. O_redirect=1 unless the winner is snpc.
    - Winner fencei: O_pc_valid=0. Go to INV and latch pend_pc=I_fencei_pc+4 (XLEN wrap-around, carry dropped).
    - Any other redirect without I_pc_ready: latch pend_pc/pend_prio, go to HOLD.
    - Redirect with I_pc_ready: pass through, stay in IDLE, zero added latency.
  - HOLD: O_pc_valid=1, O_dnpc=pend_pc, O_redirect=1. On I_pc_ready -> IDLE.
    - A new request of strictly higher priority overwrites pend_pc/pend_prio in that cycle; the overwrite wins over the handshake and the state stays HOLD.
    - Equal or lower-priority requests are ignored; they come from flushed younger instructions.
  - INV: O_icache_inv_req=1, O_pc_valid=0, O_busy=1.
    - On I_icache_inv_done -> HOLD with the pending target.
    - I_trap_valid during INV overwrites pend_pc with I_trap_pc. Invalidation is never aborted, so INV still waits for done.
    - ex/id requests in INV are ignored.
- Flushes, combinational, asserted in the cycle the request is accepted (IDLE winner, or HOLD/INV overwrite):
  - trap, fencei, ex: O_flush_ifid=1 and O_flush_idex=1.
  - id: O_flush_ifid=1 only.
  - No flush for snpc.
- O_dnpc bit0 is forced to 0 for every source.
- Simultaneous ex and id requests in IDLE: ex wins, and both flushes assert.

Decomposition:
- Shared package:
  - State encoding BOOT/IDLE/HOLD/INV (2 bits).
  - Priority codes TRAP=3, FENCEI=2, EX=1, ID=0.
  - RESET_PC default.
- Sub-module ysyx_22040750_redir_prio_sel: 4-way fixed-priority select, returning {valid, prio, pc}.
- The FSM and pending register stay in the top module.

Test Plan:
- Reset release with I_pc_ready=1: first cycle O_dnpc=32'h8000_0000, O_redirect=1. Next cycle IDLE, O_dnpc=I_snpc=32'h8000_0004.
- IDLE, I_ex_redir_valid=1, pc=32'h8000_0100, I_pc_ready=0 for 3 cycles: O_dnpc held at 32'h8000_0100 in HOLD. Flushes for 1 cycle only. Returns to IDLE on ready.
- HOLD on id target 32'h8000_0200, then I_trap_valid with 32'h8000_0040: O_dnpc switches to 32'h8000_0040. Both flushes pulse. A later id request is ignored.
- I_fencei_valid with pc=32'hFFFF_FFFC: inv_req held until done after 5 cycles. Then O_dnpc=32'h0000_0000 (wrap-around). O_busy=1 throughout INV.
- Trap during INV: target becomes the trap PC, issued only after I_icache_inv_done.
- Reset asserted mid-HOLD: outputs go to reset values immediately (asynchronous). After release, BOOT reissues RESET_PC.
